// File: rtl/store_trace_monitor_pkg.sv
// Shared types and defaults for the store trace monitor.
// Holds the trace entry layout, the FSM state encoding and the default signature constants.
package store_trace_monitor_pkg;

    localparam logic [31:0] DEFAULT_DONE_ADDR = 32'h0000_0054;
    localparam logic [31:0] DEFAULT_DONE_DATA = 32'd7;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } trace_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mon_state_t;

    // Saturating increment so a long-running program never wraps the cycle count.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        sat_inc = (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/store_trace_monitor_if.sv
// Store-port observation and host drain signals of the store trace monitor.
// master = processor/host side, slave = monitor side.
interface store_trace_monitor_if #(
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          memwrite;
    logic [31:0]   dataadr;
    logic [31:0]   writedata;
    logic [31:0]   pc;
    logic          capture_en;
    logic          rd_en;
    logic          rd_valid;
    logic [31:0]   rd_pc;
    logic [31:0]   rd_addr;
    logic [31:0]   rd_data;
    logic [CW-1:0] count;
    logic          overflow;
    logic          done;
    logic          pass;
    logic [31:0]   done_cycle;

    modport master (
        output memwrite, dataadr, writedata, pc, capture_en, rd_en,
        input  rd_valid, rd_pc, rd_addr, rd_data, count, overflow, done, pass, done_cycle
    );

    modport slave (
        input  memwrite, dataadr, writedata, pc, capture_en, rd_en,
        output rd_valid, rd_pc, rd_addr, rd_data, count, overflow, done, pass, done_cycle
    );

endinterface

// File: rtl/store_trace_monitor_trace_fifo.sv
// First-word fall-through buffer of trace entries with occupancy count.
// A push into a full buffer is accepted only when a pop frees a slot on the same edge.
module trace_fifo
    import store_trace_monitor_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  trace_entry_t  wr_entry,
    output trace_entry_t  rd_entry,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    trace_entry_t  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          pop_ok_s;
    logic          push_ok_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == CW'(0));
    assign count     = count_r;
    assign rd_entry  = mem_r[rd_ptr_r];
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= wr_entry;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/store_trace_monitor.sv
// Passive observer of the data-memory write port: traces committed stores into a
// drainable buffer and latches the end-of-program signature result and cycle.
module store_trace_monitor
    import store_trace_monitor_pkg::*;
#(
    parameter int          DEPTH     = 16,
    parameter logic [31:0] DONE_ADDR = DEFAULT_DONE_ADDR,
    parameter logic [31:0] DONE_DATA = DEFAULT_DONE_DATA
) (
    input logic                  clk,
    input logic                  reset,
    store_trace_monitor_if.slave bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    mon_state_t    state_r;
    logic [31:0]   cycle_cnt_r;
    logic          overflow_r;
    logic          done_r;
    logic          pass_r;
    logic [31:0]   done_cycle_r;

    logic          store_s;
    logic          sig_s;
    logic          full_s;
    logic          empty_s;
    logic [CW-1:0] count_s;
    trace_entry_t  wr_entry_s;
    trace_entry_t  head_s;

    // A store counts while capturing, including the IDLE cycle that arms capture.
    always_comb begin
        store_s = 1'b0;
        case (state_r)
            IDLE:    store_s = bus.memwrite && bus.capture_en;
            RUN:     store_s = bus.memwrite && bus.capture_en;
            DONE:    store_s = 1'b0;
            default: store_s = 1'b0;
        endcase
    end

    assign sig_s      = store_s && (bus.dataadr == DONE_ADDR);
    assign wr_entry_s = '{pc: bus.pc, addr: bus.dataadr, data: bus.writedata};

    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (reset),
        .push     (store_s),
        .pop      (bus.rd_en),
        .wr_entry (wr_entry_s),
        .rd_entry (head_s),
        .full     (full_s),
        .empty    (empty_s),
        .count    (count_s)
    );

    // Capture FSM, cycle counter, signature latch and sticky overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            cycle_cnt_r  <= 32'd0;
            overflow_r   <= 1'b0;
            done_r       <= 1'b0;
            pass_r       <= 1'b0;
            done_cycle_r <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.capture_en) begin
                        state_r <= sig_s ? DONE : RUN;
                    end
                end
                RUN: begin
                    cycle_cnt_r <= sat_inc(cycle_cnt_r);
                    if (sig_s) begin
                        state_r <= DONE;
                    end
                end
                DONE:    state_r <= DONE;
                default: state_r <= IDLE;
            endcase
            if (sig_s) begin
                done_r       <= 1'b1;
                pass_r       <= (bus.writedata == DONE_DATA);
                done_cycle_r <= cycle_cnt_r;
            end
            // A full buffer only makes room when a pop lands on the same edge.
            if (store_s && full_s && !bus.rd_en) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign bus.rd_valid   = !empty_s;
    assign bus.rd_pc      = head_s.pc;
    assign bus.rd_addr    = head_s.addr;
    assign bus.rd_data    = head_s.data;
    assign bus.count      = count_s;
    assign bus.overflow   = overflow_r;
    assign bus.done       = done_r;
    assign bus.pass       = pass_r;
    assign bus.done_cycle = done_cycle_r;

endmodule

// File: tb/tb_store_trace_monitor.sv
// Scoreboard bench for store_trace_monitor: stimulus queues expected trace entries,
// a negedge monitor pops and compares every accepted read.
module tb_store_trace_monitor;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    logic [95:0] exp_q[$];

    store_trace_monitor_if #(.DEPTH(16)) bus ();

    store_trace_monitor #(
        .DEPTH     (16),
        .DONE_ADDR (32'h0000_0054),
        .DONE_DATA (32'd7)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted pop must match the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && bus.rd_en && bus.rd_valid) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_pop", {bus.rd_pc, bus.rd_addr, bus.rd_data}, 96'hx);
            end else begin
                chk("sb_head", {bus.rd_pc, bus.rd_addr, bus.rd_data}, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic mw, input logic ce, input logic re,
                       input logic [31:0] p, input logic [31:0] a, input logic [31:0] d,
                       input bit cap);
        bus.memwrite   = mw;
        bus.capture_en = ce;
        bus.rd_en      = re;
        bus.pc         = p;
        bus.dataadr    = a;
        bus.writedata  = d;
        if (cap) exp_q.push_back({p, a, d});
        tick();
        bus.memwrite = 1'b0;
        bus.rd_en    = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            chk("drain_valid", {95'd0, bus.rd_valid}, 96'd1);
            cyc(1'b0, 1'b1, 1'b1, 32'd0, 32'd0, 32'd0, 1'b0);
        end
        chk("drain_empty", {95'd0, bus.rd_valid}, 96'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_count"},    {91'd0, bus.count}, 96'd0);
        chk({tag, "_rd_valid"}, {95'd0, bus.rd_valid}, 96'd0);
        chk({tag, "_overflow"}, {95'd0, bus.overflow}, 96'd0);
        chk({tag, "_done"},     {95'd0, bus.done}, 96'd0);
        chk({tag, "_pass"},     {95'd0, bus.pass}, 96'd0);
        chk({tag, "_done_cyc"}, {64'd0, bus.done_cycle}, 96'd0);
        chk({tag, "_head"},     {bus.rd_pc, bus.rd_addr, bus.rd_data}, 96'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        bus.memwrite = 1'b0; bus.capture_en = 1'b0; bus.rd_en = 1'b0;
        bus.pc = 32'd0; bus.dataadr = 32'd0; bus.writedata = 32'd0;
        tick();
        tick();
        chk_all_zero("reset");
        reset = 1'b0;

        // Stores and pops before capture is armed are ignored, signature included.
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b1, 32'h100 + 32'(i), 32'h54, 32'd7, 1'b0);
        chk("idle_count", {91'd0, bus.count}, 96'd0);
        chk("idle_valid", {95'd0, bus.rd_valid}, 96'd0);
        chk("idle_done", {95'd0, bus.done}, 96'd0);

        // Basic capture: the arming cycle's store is recorded.
        cyc(1'b1, 1'b1, 1'b0, 32'h10, 32'h20, 32'hA, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 32'h14, 32'h24, 32'hB, 1'b1);
        chk("basic_count", {91'd0, bus.count}, 96'd2);
        chk("basic_head", {bus.rd_pc, bus.rd_addr, bus.rd_data}, {32'h10, 32'h20, 32'hA});
        drain(2);

        // 17 stores into a 16-deep buffer; the last one is dropped.
        for (int i = 0; i < 17; i++)
            cyc(1'b1, 1'b1, 1'b0, 32'h200 + 32'(4*i), 32'h400 + 32'(4*i), 32'h1000 + 32'(i), i < 16);
        chk("ovf_count", {91'd0, bus.count}, 96'd16);
        chk("ovf_flag", {95'd0, bus.overflow}, 96'd1);
        drain(16);
        chk("ovf_drained_count", {91'd0, bus.count}, 96'd0);

        // Full buffer with simultaneous push and pop.
        do_reset();
        for (int i = 0; i < 16; i++)
            cyc(1'b1, 1'b1, 1'b0, 32'h300 + 32'(4*i), 32'h500 + 32'(4*i), 32'h2000 + 32'(i), 1'b1);
        chk("full_count", {91'd0, bus.count}, 96'd16);
        cyc(1'b1, 1'b1, 1'b1, 32'h3FC, 32'h5FC, 32'h2FFF, 1'b1);
        chk("pushpop_count", {91'd0, bus.count}, 96'd16);
        chk("pushpop_overflow", {95'd0, bus.overflow}, 96'd0);
        drain(16);

        // Passing signature on the 9th RUN cycle; idle memwrite first keeps cycle_cnt at 0.
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 32'h700, 32'h54, 32'd7, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
        for (int r = 1; r <= 8; r++) begin
            if (r == 3) cyc(1'b1, 1'b1, 1'b0, 32'h710, 32'h60, 32'h33, 1'b1);
            else        cyc(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
        end
        cyc(1'b1, 1'b1, 1'b0, 32'h720, 32'h54, 32'd7, 1'b1);
        chk("sig_done", {95'd0, bus.done}, 96'd1);
        chk("sig_pass", {95'd0, bus.pass}, 96'd1);
        chk("sig_done_cycle", {64'd0, bus.done_cycle}, 96'd8);
        chk("sig_count", {91'd0, bus.count}, 96'd2);
        cyc(1'b1, 1'b1, 1'b0, 32'h724, 32'h30, 32'h99, 1'b0);
        chk("after_done_count", {91'd0, bus.count}, 96'd2);
        drain(2);

        // Failing signature, then reset in the middle of draining.
        do_reset();
        cyc(1'b1, 1'b1, 1'b0, 32'h800, 32'h80, 32'h1, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 32'h804, 32'h54, 32'd5, 1'b1);
        chk("fail_done", {95'd0, bus.done}, 96'd1);
        chk("fail_pass", {95'd0, bus.pass}, 96'd0);
        chk("fail_done_cycle", {64'd0, bus.done_cycle}, 96'd0);
        chk("fail_count", {91'd0, bus.count}, 96'd2);
        cyc(1'b0, 1'b1, 1'b1, 32'd0, 32'd0, 32'd0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("midreset");
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, 32'h880, 32'h88, 32'h8, 1'b0);
        chk("post_reset_count", {91'd0, bus.count}, 96'd0);
        cyc(1'b1, 1'b1, 1'b0, 32'h900, 32'h90, 32'h5, 1'b1);
        chk("rearm_count", {91'd0, bus.count}, 96'd1);
        chk("rearm_done", {95'd0, bus.done}, 96'd0);
        drain(1);

        chk("sb_leftover", 96'(exp_q.size()), 96'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/store_trace_monitor.md
Name: store_trace_monitor

Overview:
- Passive observer on the pipelined processor's data-memory write port (memwrite, ALU address, write data, PC of the store).
- Records every committed store into a small first-word-fall-through buffer that a host or bench drains through a valid/read handshake.
- Detects the end-of-program signature store and latches pass/fail plus the cycle count.
- Sits beside the processor top as the consumer of its store traffic. It never drives the processor.

Parameters:
- DEPTH, 16: trace entries held; must be a power of two, at least 2.
- DONE_ADDR, 32'h0000_0054: address of the end-of-program signature store.
- DONE_DATA, 32'd7: data value that means pass when written to DONE_ADDR.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- memwrite  in  1  processor store strobe, memory stage.
- dataadr  in  32  store address (ALU result).
- writedata  in  32  store data.
- pc  in  32  PC of the storing instruction.
- capture_en  in  1  arms capture; IDLE leaves on the first cycle this is high.
- rd_en  in  1  host pops the head entry.
- rd_valid  out  1  buffer non-empty; rd_pc, rd_addr and rd_data are meaningful.
- rd_pc  out  32  head entry PC.
- rd_addr  out  32  head entry address.
- rd_data  out  32  head entry data.
- count  out  $clog2(DEPTH)+1  occupancy.
- overflow  out  1  sticky; a store was dropped because the buffer was full.
- done  out  1  sticky; the signature store was seen.
- pass  out  1  valid only when done; 1 if the signature data equalled DONE_DATA.
- done_cycle  out  32  value of cycle_cnt when done was set.

Behaviour:
- Reset (asynchronous, any time, including mid-run): FSM goes to IDLE and the buffer empties. count, rd_valid, overflow, done, pass and done_cycle all go to 0; rd_pc, rd_addr and rd_data read 0; cycle_cnt goes to 0.
- cycle_cnt: 32-bit internal counter. Increments every clock while the FSM is in RUN and saturates at 32'hFFFF_FFFF.
- FSM, IDLE: memwrite is ignored. Moves to RUN on a clock where capture_en=1; that same cycle's store is captured.
- FSM, RUN: a store is any clock with memwrite=1 and capture_en=1. Each store is pushed as {pc, dataadr, writedata}.
- Signature store: a store with dataadr==DONE_ADDR is still pushed, and on that edge:
  - done<=1, pass<=(writedata==DONE_DATA), done_cycle<=cycle_cnt (the pre-increment value);
  - FSM moves to DONE.
- FSM, DONE: terminal until reset. Further stores are ignored. Popping continues to work.
- Push latency: one cycle. The entry appears at the head (when the buffer was empty) and count updates after the capturing edge.
- Pop: rd_en=1 with rd_valid=1 removes the head on that edge. rd_en with rd_valid=0 is ignored and does not underflow.
- Full, no pop: the push is dropped, overflow<=1 (sticky), count stays DEPTH.
- Full, with pop: the push and pop are both accepted on the same edge and count is unchanged.
- Empty, push and pop together: the pop is ignored and the push is accepted.
- Pointer arithmetic: read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count is 0..DEPTH inclusive.
- Head outputs: driven combinationally from storage at the read pointer (first-word fall-through). They hold their last value while empty; the bench checks them only when rd_valid=1.

Decomposition:
- Shared package:
  - trace_entry_t, a packed struct {pc, addr, data} of 3x32 bits;
  - mon_state_t enum {IDLE, RUN, DONE};
  - default constants DONE_ADDR and DONE_DATA.
- One sub-module: trace_fifo. Parameterised on DEPTH, holds trace_entry_t, first-word fall-through, with push, pop, full, empty and count. It contains no knowledge of the signature store.
- Top level contains the FSM, cycle counter, signature compare and overflow logic.

Test Plan:
- Reset, capture_en=1, stores (pc=0x10, adr=0x20, d=0xA), then (0x14, 0x24, 0xB) -> count=2, head is {0x10, 0x20, 0xA}; pop twice -> {0x14, 0x24, 0xB}, then rd_valid=0.
- Push 17 stores with no pops (DEPTH=16) -> count=16, overflow=1, 17th store absent; drain returns 16 entries in order, through pointer wrap.
- Buffer full, push and pop on the same edge -> count stays 16, overflow stays 0, new entry appears last on drain.
- Store (adr=0x54, d=7) on the 9th RUN cycle -> done=1, pass=1, done_cycle=8; later store to 0x30 is not captured.
- Store (adr=0x54, d=5) -> done=1, pass=0; then assert reset mid-drain -> all outputs 0, FSM in IDLE, memwrite ignored until capture_en.
- memwrite pulses while capture_en=0 from reset -> count=0 and cycle_cnt held at 0; rd_en on empty -> no change.
